// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, payload and status signals crossing one pipeline stage register.
// master drives the upstream side; slave is the stage register itself.
interface pipe_stage_reg_if #(
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_DATA = 2,
   parameter int unsigned REG_W    = 4,
   parameter int unsigned NUM_REG  = 3,
   parameter int unsigned FLAG_W   = 1,
   parameter int unsigned CNT_W    = 16
);
   logic                        stall_en;
   logic                        flush;
   logic                        cnt_clr;
   logic                        valid_in;
   logic [INSTR_W-1:0]          instr_in;
   logic [NUM_DATA*DATA_W-1:0]  data_in;
   logic [NUM_REG*REG_W-1:0]    reg_in;
   logic [FLAG_W-1:0]           flag_in;

   logic                        valid_out;
   logic [INSTR_W-1:0]          instr_out;
   logic [NUM_DATA*DATA_W-1:0]  data_out;
   logic [NUM_REG*REG_W-1:0]    reg_out;
   logic [FLAG_W-1:0]           flag_out;
   logic [CNT_W-1:0]            stall_cnt;
   logic [CNT_W-1:0]            bubble_cnt;

   modport master (
      output stall_en, flush, cnt_clr, valid_in, instr_in, data_in, reg_in, flag_in,
      input  valid_out, instr_out, data_out, reg_out, flag_out, stall_cnt, bubble_cnt
   );

   modport slave (
      input  stall_en, flush, cnt_clr, valid_in, instr_in, data_in, reg_in, flag_in,
      output valid_out, instr_out, data_out, reg_out, flag_out, stall_cnt, bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable pipeline stage register: valid bit, flush-to-bubble, stall hold,
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
   parameter int unsigned        INSTR_W   = 16,
   parameter int unsigned        DATA_W    = 16,
   parameter int unsigned        NUM_DATA  = 2,
   parameter int unsigned        REG_W     = 4,
   parameter int unsigned        NUM_REG   = 3,
   parameter int unsigned        FLAG_W    = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int unsigned        CNT_W     = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipe_stage_reg_if.slave   bus
);

   logic                        valid_q;
   logic [INSTR_W-1:0]          instr_q;
   logic [NUM_DATA*DATA_W-1:0]  data_q;
   logic [NUM_REG*REG_W-1:0]    reg_q;
   logic [FLAG_W-1:0]           flag_q;
   logic [CNT_W-1:0]            stall_cnt_q;
   logic [CNT_W-1:0]            bubble_cnt_q;

   logic                        stall_hit;
   logic                        bubble_hit;

   // Flush outranks stall, so a simultaneous stall is not counted.
   always_comb begin
      stall_hit  = bus.stall_en && !bus.flush && valid_q;
      bubble_hit = bus.flush && valid_q;
   end

   // data_q is left untouched on flush: it is don't-care once valid drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         data_q  <= '0;
         reg_q   <= '0;
         flag_q  <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         reg_q   <= '0;
         flag_q  <= '0;
      end else if (!bus.stall_en) begin
         valid_q <= bus.valid_in;
         instr_q <= bus.instr_in;
         data_q  <= bus.data_in;
         reg_q   <= bus.reg_in;
         flag_q  <= bus.flag_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (bus.cnt_clr) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (stall_hit && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (bubble_hit && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.valid_out  = valid_q;
   assign bus.instr_out  = instr_q;
   assign bus.data_out   = data_q;
   assign bus.reg_out    = reg_q;
   assign bus.flag_out   = flag_q;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg against a behavioural model;
// two instances share stimulus, one with 16-bit and one with 2-bit counters.
module tb_pipe_stage_reg;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   pipe_stage_reg_if #(.CNT_W(16)) bus16 ();
   pipe_stage_reg_if #(.CNT_W(2))  bus2  ();

   pipe_stage_reg #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipe_stage_reg #(.CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus mirror, shared by both instances
   logic        s_stall, s_flush, s_clr, s_valid, s_flag;
   logic [15:0] s_instr;
   logic [31:0] s_data;
   logic [11:0] s_reg;

   // reference state
   logic        m_valid, m_flag;
   logic [15:0] m_instr;
   logic [31:0] m_data;
   logic [11:0] m_reg;
   int unsigned m_sc16, m_bc16, m_sc2, m_bc2;

   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned cap);
      return (v >= cap) ? cap : v + 1;
   endfunction

   task automatic drive(input logic st, input logic fl, input logic clr, input logic v,
                        input logic [15:0] ins, input logic [31:0] d,
                        input logic [11:0] r, input logic f);
      s_stall = st; s_flush = fl; s_clr = clr; s_valid = v;
      s_instr = ins; s_data = d; s_reg = r; s_flag = f;
      bus16.stall_en = st; bus16.flush = fl; bus16.cnt_clr = clr; bus16.valid_in = v;
      bus16.instr_in = ins; bus16.data_in = d; bus16.reg_in = r; bus16.flag_in = f;
      bus2.stall_en  = st; bus2.flush  = fl; bus2.cnt_clr  = clr; bus2.valid_in  = v;
      bus2.instr_in  = ins; bus2.data_in  = d; bus2.reg_in  = r; bus2.flag_in  = f;
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_instr = 16'h0000; m_data = '0; m_reg = '0; m_flag = 1'b0;
      m_sc16 = 0; m_bc16 = 0; m_sc2 = 0; m_bc2 = 0;
   endtask

   task automatic model_edge();
      bit stall_hit;
      bit bubble_hit;
      stall_hit  = s_stall && !s_flush && m_valid;
      bubble_hit = s_flush && m_valid;
      if (s_clr) begin
         m_sc16 = 0; m_bc16 = 0; m_sc2 = 0; m_bc2 = 0;
      end else begin
         if (stall_hit)  begin m_sc16 = sat_inc(m_sc16, 65535); m_sc2 = sat_inc(m_sc2, 3); end
         if (bubble_hit) begin m_bc16 = sat_inc(m_bc16, 65535); m_bc2 = sat_inc(m_bc2, 3); end
      end
      if (s_flush) begin
         m_valid = 1'b0; m_instr = 16'h0000; m_reg = '0; m_flag = 1'b0;
      end else if (!s_stall) begin
         m_valid = s_valid; m_instr = s_instr; m_data = s_data; m_reg = s_reg; m_flag = s_flag;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".valid16"},  64'(bus16.valid_out),  64'(m_valid));
      chk({ph, ".instr16"},  64'(bus16.instr_out),  64'(m_instr));
      chk({ph, ".data16"},   64'(bus16.data_out),   64'(m_data));
      chk({ph, ".reg16"},    64'(bus16.reg_out),    64'(m_reg));
      chk({ph, ".flag16"},   64'(bus16.flag_out),   64'(m_flag));
      chk({ph, ".stall16"},  64'(bus16.stall_cnt),  64'(m_sc16));
      chk({ph, ".bubble16"}, 64'(bus16.bubble_cnt), 64'(m_bc16));
      chk({ph, ".valid2"},   64'(bus2.valid_out),   64'(m_valid));
      chk({ph, ".instr2"},   64'(bus2.instr_out),   64'(m_instr));
      chk({ph, ".reg2"},     64'(bus2.reg_out),     64'(m_reg));
      chk({ph, ".stall2"},   64'(bus2.stall_cnt),   64'(m_sc2));
      chk({ph, ".bubble2"},  64'(bus2.bubble_cnt),  64'(m_bc2));
   endtask

   // one rising edge; outputs sampled 1 time unit later
   task automatic tick(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 32'hDEADBEEF, 12'hFFF, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.nop", 64'(bus16.instr_out), 64'h0000);
      rst_n = 1'b1;

      // pass-through
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hA123, {16'h00FF, 16'h1234}, 12'h321, 1'b1);
      tick("pass");
      chk("pass.instr",  64'(bus16.instr_out), 64'hA123);
      chk("pass.lane0",  64'(bus16.data_out[15:0]), 64'h1234);
      chk("pass.lane1",  64'(bus16.data_out[31:16]), 64'h00FF);
      chk("pass.reg",    64'(bus16.reg_out), 64'h321);

      // stall hold for 3 cycles while inputs change
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hB001, 32'h0000B001, 12'h111, 1'b0);
      tick("loadB");
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000 + 16'(i), 32'(i), 12'(i), 1'b1);
         tick("stall");
      end
      chk("stall.instr", 64'(bus16.instr_out), 64'hB001);
      chk("stall.cnt",   64'(bus16.stall_cnt), 64'd3);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hC0DE, 32'h12345678, 12'h456, 1'b1);
      tick("release");
      chk("release.instr", 64'(bus16.instr_out), 64'hC0DE);

      // flush with valid data, then flush while already invalid
      drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hEEEE, 32'h0, 12'hEEE, 1'b1);
      tick("flush1");
      chk("flush1.valid",  64'(bus16.valid_out), 64'd0);
      chk("flush1.bubble", 64'(bus16.bubble_cnt), 64'd1);
      tick("flush2");
      chk("flush2.bubble", 64'(bus16.bubble_cnt), 64'd1);

      // flush and stall together
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hD00D, 32'hAAAA5555, 12'hABC, 1'b1);
      tick("loadD");
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h7777, 32'h7777, 12'h777, 1'b0);
      tick("flushstall");
      chk("flushstall.stall", 64'(bus16.stall_cnt), 64'd3);
      chk("flushstall.instr", 64'(bus16.instr_out), 64'h0000);

      // saturation of the 2-bit counter, then clear during a stall
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 32'h11111111, 12'h111, 1'b1);
      tick("loadS");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 32'h0, 12'h0, 1'b0);
      for (int i = 0; i < 5; i++) tick("sat");
      chk("sat.cnt2",  64'(bus2.stall_cnt), 64'd3);
      chk("sat.cnt16", 64'(bus16.stall_cnt), 64'd5);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 32'h0, 12'h0, 1'b0);
      tick("clr");
      chk("clr.cnt2", 64'(bus2.stall_cnt), 64'd0);

      // asynchronous reset between edges while stalled with valid data
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h3333, 32'h33333333, 12'h333, 1'b1);
      tick("loadR");
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 32'h4444, 12'h444, 1'b0);
      tick("stallR");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async");
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // random traffic
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               16'($urandom()), 32'($urandom()), 12'($urandom()), 1'($urandom()));
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
